// File: rtl/ula_arbiter_if.sv
// -----------------------------------------------------------------------------
// ula_arbiter_if
// Bundles everything between two requesters, the arbiter and the shared
// enable-gated ALU units.
//   Requester side : req0/req1, op0/op1, a0/b0/a1/b1 (in), gnt*, done*, res,
//                    busy (out)
//   ALU side       : alu_a, alu_b, en_and/en_or/en_xor/en_add (out),
//                    alu_s (OR of the enabled unit outputs, in)
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus the ALU units)
// -----------------------------------------------------------------------------
interface ula_arbiter_if;
   logic       req0;
   logic       req1;
   logic [1:0] op0;
   logic [1:0] op1;
   logic [7:0] a0;
   logic [7:0] b0;
   logic [7:0] a1;
   logic [7:0] b1;
   logic       gnt0;
   logic       gnt1;
   logic       done0;
   logic       done1;
   logic [7:0] res;
   logic       busy;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic       en_and;
   logic       en_or;
   logic       en_xor;
   logic       en_add;
   logic [7:0] alu_s;

   modport slave (
      input  req0, req1, op0, op1, a0, b0, a1, b1, alu_s,
      output gnt0, gnt1, done0, done1, res, busy,
             alu_a, alu_b, en_and, en_or, en_xor, en_add
   );

   modport master (
      output req0, req1, op0, op1, a0, b0, a1, b1, alu_s,
      input  gnt0, gnt1, done0, done1, res, busy,
             alu_a, alu_b, en_and, en_or, en_xor, en_add
   );
endinterface

// File: rtl/ula_arbiter.sv
// -----------------------------------------------------------------------------
// ula_arbiter
// Round-robin arbiter that lets two requesters share one set of enable-gated
// ALU units (AND/OR/XOR/ADD). Each transaction walks IDLE -> GRANT -> EXEC ->
// RESP -> IDLE, one cycle per non-IDLE state.
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   arb_if - ula_arbiter_if.slave (requests, grants, result, ALU drive)
// All outputs are registered; they are computed from the next state so that
// they line up with the state register.
// -----------------------------------------------------------------------------
module ula_arbiter (
   input  logic           clk,
   input  logic           rst_n,
   ula_arbiter_if.slave   arb_if
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      EXEC  = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_ADD = 2'b11;

   state_e     state_q, state_d;
   logic       owner_q, owner_d;   // 0: requester 0, 1: requester 1
   logic       last_q,  last_d;    // last granted requester
   logic [1:0] op_q,    op_d;
   logic [7:0] alu_a_q, alu_a_d;
   logic [7:0] alu_b_q, alu_b_d;
   logic [7:0] res_q,   res_d;
   logic       gnt0_q,  gnt0_d;
   logic       gnt1_q,  gnt1_d;
   logic       done0_q, done0_d;
   logic       done1_q, done1_d;
   logic       busy_q,  busy_d;
   logic       en_and_q, en_and_d;
   logic       en_or_q,  en_or_d;
   logic       en_xor_q, en_xor_d;
   logic       en_add_q, en_add_d;
   logic       winner_s;

   // Round-robin pick: a lone request wins, a tie goes to the one not served last
   always_comb begin
      winner_s = last_q;
      if (arb_if.req0 && arb_if.req1) begin
         winner_s = ~last_q;
      end else if (arb_if.req0) begin
         winner_s = 1'b0;
      end else begin
         winner_s = 1'b1;
      end
   end

   // Next-state and datapath-capture logic
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      op_d    = op_q;
      alu_a_d = alu_a_q;
      alu_b_d = alu_b_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (arb_if.req0 || arb_if.req1) begin
               state_d = GRANT;
               owner_d = winner_s;
               last_d  = winner_s;
               op_d    = winner_s ? arb_if.op1 : arb_if.op0;
               alu_a_d = winner_s ? arb_if.a1  : arb_if.a0;
               alu_b_d = winner_s ? arb_if.b1  : arb_if.b0;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: state_d = EXEC;
         EXEC: begin
            state_d = RESP;
            res_d   = arb_if.alu_s;   // ADD wraps inside the 8-bit ALU unit
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode from the next state, registered alongside it
   always_comb begin
      busy_d   = (state_d != IDLE);
      gnt0_d   = busy_d && !owner_d;
      gnt1_d   = busy_d &&  owner_d;
      done0_d  = (state_d == RESP) && !owner_d;
      done1_d  = (state_d == RESP) &&  owner_d;
      en_and_d = 1'b0;
      en_or_d  = 1'b0;
      en_xor_d = 1'b0;
      en_add_d = 1'b0;
      if (state_d == EXEC) begin
         case (op_d)
            OP_AND:  en_and_d = 1'b1;
            OP_OR:   en_or_d  = 1'b1;
            OP_XOR:  en_xor_d = 1'b1;
            OP_ADD:  en_add_d = 1'b1;
            default: en_and_d = 1'b0;
         endcase
      end else begin
         en_and_d = 1'b0;
      end
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;   // requester 0 wins the first tie
         op_q     <= 2'b00;
         alu_a_q  <= 8'h00;
         alu_b_q  <= 8'h00;
         res_q    <= 8'h00;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         busy_q   <= 1'b0;
         en_and_q <= 1'b0;
         en_or_q  <= 1'b0;
         en_xor_q <= 1'b0;
         en_add_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         op_q     <= op_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         res_q    <= res_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         busy_q   <= busy_d;
         en_and_q <= en_and_d;
         en_or_q  <= en_or_d;
         en_xor_q <= en_xor_d;
         en_add_q <= en_add_d;
      end
   end

   assign arb_if.gnt0   = gnt0_q;
   assign arb_if.gnt1   = gnt1_q;
   assign arb_if.done0  = done0_q;
   assign arb_if.done1  = done1_q;
   assign arb_if.res    = res_q;
   assign arb_if.busy   = busy_q;
   assign arb_if.alu_a  = alu_a_q;
   assign arb_if.alu_b  = alu_b_q;
   assign arb_if.en_and = en_and_q;
   assign arb_if.en_or  = en_or_q;
   assign arb_if.en_xor = en_xor_q;
   assign arb_if.en_add = en_add_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ula_arbiter
// Directed bench for ula_arbiter. Models the enable-gated ALU units, drives
// requests at the falling edge and samples outputs at the falling edge.
// Output status word: {busy, gnt1, gnt0, done1, done0, en_add, en_xor, en_or,
// en_and}.
// -----------------------------------------------------------------------------
module tb_ula_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   ula_arbiter_if u_if ();

   always #5 clk = ~clk;

   ula_arbiter u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .arb_if (u_if)
   );

   // Enable-gated ALU units: disabled units contribute zero to the OR
   logic [7:0] sum_s;
   assign sum_s = u_if.alu_a + u_if.alu_b;
   assign u_if.alu_s = ({8{u_if.en_and}} & (u_if.alu_a & u_if.alu_b)) |
                       ({8{u_if.en_or}}  & (u_if.alu_a | u_if.alu_b)) |
                       ({8{u_if.en_xor}} & (u_if.alu_a ^ u_if.alu_b)) |
                       ({8{u_if.en_add}} & sum_s);

   function automatic logic [8:0] status();
      return {u_if.busy, u_if.gnt1, u_if.gnt0, u_if.done1, u_if.done0,
              u_if.en_add, u_if.en_xor, u_if.en_or, u_if.en_and};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      u_if.req0 = 1'b0; u_if.req1 = 1'b0;
      u_if.op0  = 2'b00; u_if.op1 = 2'b00;
      u_if.a0   = 8'h00; u_if.b0  = 8'h00;
      u_if.a1   = 8'h00; u_if.b1  = 8'h00;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      #1;
      checks++;
      if (status() !== 9'b000000000) begin
         errors++; $display("FAIL reset_status: got %b expected %b", status(), 9'b000000000);
      end
      checks++;
      if ({u_if.res, u_if.alu_a, u_if.alu_b} !== 24'h000000) begin
         errors++; $display("FAIL reset_data: got %h expected %h", {u_if.res, u_if.alu_a, u_if.alu_b}, 24'h000000);
      end
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if (status() !== 9'b000000000) begin
         errors++; $display("FAIL reset_idle: got %b expected %b", status(), 9'b000000000);
      end
   endtask

   task automatic test_single_and();
      logic [8:0] exp_st [4] = '{9'b101000000, 9'b101000001, 9'b101010000, 9'b000000000};
      u_if.req0 = 1'b1; u_if.op0 = 2'b00; u_if.a0 = 8'h35; u_if.b0 = 8'h94;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (status() !== exp_st[i]) begin
            errors++; $display("FAIL and_status cyc %0d: got %b expected %b", i, status(), exp_st[i]);
         end
         if (i == 0) begin
            checks++;
            if ({u_if.alu_a, u_if.alu_b} !== 16'h3594) begin
               errors++; $display("FAIL and_operands: got %h expected %h", {u_if.alu_a, u_if.alu_b}, 16'h3594);
            end
         end
         if (i == 2) u_if.req0 = 1'b0;
         if (i >= 2) begin
            checks++;
            if (u_if.res !== 8'h14) begin
               errors++; $display("FAIL and_res cyc %0d: got %h expected %h", i, u_if.res, 8'h14);
            end
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [8:0] exp_st [8] = '{9'b101000000, 9'b101000100, 9'b101010000, 9'b000000000,
                                 9'b110000000, 9'b110000010, 9'b110100000, 9'b000000000};
      do_reset();
      u_if.req0 = 1'b1; u_if.op0 = 2'b10; u_if.a0 = 8'hAA; u_if.b0 = 8'h55;
      u_if.req1 = 1'b1; u_if.op1 = 2'b01; u_if.a1 = 8'hE1; u_if.b1 = 8'hE1;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (status() !== exp_st[i]) begin
            errors++; $display("FAIL simul_status cyc %0d: got %b expected %b", i, status(), exp_st[i]);
         end
         if (i == 2) begin
            checks++;
            if (u_if.res !== 8'hFF) begin
               errors++; $display("FAIL simul_res0: got %h expected %h", u_if.res, 8'hFF);
            end
            u_if.req0 = 1'b0;
         end
         if (i == 6) begin
            checks++;
            if (u_if.res !== 8'hE1) begin
               errors++; $display("FAIL simul_res1: got %h expected %h", u_if.res, 8'hE1);
            end
            u_if.req1 = 1'b0;
         end
      end
   endtask

   task automatic test_add_wrap();
      logic [8:0] exp_st [4] = '{9'b110000000, 9'b110001000, 9'b110100000, 9'b000000000};
      u_if.req1 = 1'b1; u_if.op1 = 2'b11; u_if.a1 = 8'hFF; u_if.b1 = 8'h02;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (status() !== exp_st[i]) begin
            errors++; $display("FAIL add_status cyc %0d: got %b expected %b", i, status(), exp_st[i]);
         end
         if (i == 2) begin
            checks++;
            if (u_if.res !== 8'h01) begin
               errors++; $display("FAIL add_res: got %h expected %h", u_if.res, 8'h01);
            end
            u_if.req1 = 1'b0;
         end
      end
   endtask

   task automatic test_fairness();
      logic [8:0] exp_st [8] = '{9'b101000000, 9'b101000001, 9'b101010000, 9'b000000000,
                                 9'b110000000, 9'b110001000, 9'b110100000, 9'b000000000};
      logic [7:0] exp_res [2] = '{8'h0C, 8'h30};
      do_reset();
      u_if.req0 = 1'b1; u_if.op0 = 2'b00; u_if.a0 = 8'h0F; u_if.b0 = 8'h3C;
      u_if.req1 = 1'b1; u_if.op1 = 2'b11; u_if.a1 = 8'h10; u_if.b1 = 8'h20;
      for (int i = 0; i < 16; i++) begin
         step();
         checks++;
         if (status() !== exp_st[i % 8]) begin
            errors++; $display("FAIL fair_status cyc %0d: got %b expected %b", i, status(), exp_st[i % 8]);
         end
         if ((i % 4) == 2) begin
            checks++;
            if (u_if.res !== exp_res[(i / 4) % 2]) begin
               errors++; $display("FAIL fair_res cyc %0d: got %h expected %h", i, u_if.res, exp_res[(i / 4) % 2]);
            end
         end
      end
      u_if.req0 = 1'b0;
      u_if.req1 = 1'b0;
   endtask

   task automatic test_isolation();
      logic [8:0] exp_st [4] = '{9'b101000000, 9'b101001000, 9'b101010000, 9'b000000000};
      u_if.req0 = 1'b1; u_if.op0 = 2'b11; u_if.a0 = 8'h80; u_if.b0 = 8'h81;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (status() !== exp_st[i]) begin
            errors++; $display("FAIL iso_status cyc %0d: got %b expected %b", i, status(), exp_st[i]);
         end
         if (i < 2) begin
            // Scramble the requester's inputs while the transaction is in flight
            u_if.op0 = 2'b00; u_if.a0 = 8'h00 + 8'(i); u_if.b0 = 8'h00;
         end
         if (i == 1) begin
            checks++;
            if ({u_if.alu_a, u_if.alu_b} !== 16'h8081) begin
               errors++; $display("FAIL iso_operands: got %h expected %h", {u_if.alu_a, u_if.alu_b}, 16'h8081);
            end
         end
         if (i == 2) begin
            checks++;
            if (u_if.res !== 8'h01) begin
               errors++; $display("FAIL iso_res: got %h expected %h", u_if.res, 8'h01);
            end
            u_if.req0 = 1'b0;
         end
      end
   endtask

   task automatic test_reset_exec();
      logic [8:0] exp_st [4] = '{9'b110000000, 9'b110000010, 9'b110100000, 9'b000000000};
      u_if.req0 = 1'b1; u_if.op0 = 2'b10; u_if.a0 = 8'hF0; u_if.b0 = 8'h3C;
      step();
      step();
      checks++;
      if (status() !== 9'b101000100) begin
         errors++; $display("FAIL rexec_pre: got %b expected %b", status(), 9'b101000100);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (status() !== 9'b000000000) begin
         errors++; $display("FAIL rexec_status: got %b expected %b", status(), 9'b000000000);
      end
      checks++;
      if ({u_if.res, u_if.alu_a, u_if.alu_b} !== 24'h000000) begin
         errors++; $display("FAIL rexec_data: got %h expected %h", {u_if.res, u_if.alu_a, u_if.alu_b}, 24'h000000);
      end
      u_if.req0 = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if (status() !== 9'b000000000) begin
         errors++; $display("FAIL rexec_nodone: got %b expected %b", status(), 9'b000000000);
      end
      u_if.req1 = 1'b1; u_if.op1 = 2'b01; u_if.a1 = 8'h0C; u_if.b1 = 8'h30;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (status() !== exp_st[i]) begin
            errors++; $display("FAIL rexec_txn cyc %0d: got %b expected %b", i, status(), exp_st[i]);
         end
         if (i == 2) begin
            checks++;
            if (u_if.res !== 8'h3C) begin
               errors++; $display("FAIL rexec_res: got %h expected %h", u_if.res, 8'h3C);
            end
            u_if.req1 = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_and();
      test_simultaneous();
      test_add_wrap();
      test_fairness();
      test_isolation();
      test_reset_exec();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ula_arbiter.md
ULA_ARBITER -- requirements
Module: ula_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low; no other reset exists.
REQ-003 req0, req1  input  1 each  operation request from requester 0 / 1.
REQ-004 op0, op1  input  2 each  opcode: 00 AND, 01 OR, 10 XOR, 11 ADD.
REQ-005 a0, b0, a1, b1  input  8 each  operands of requester 0 / 1.
REQ-006 gnt0, gnt1  output  1 each  requester currently owns the ALU.
REQ-007 done0, done1  output  1 each  one-cycle result-valid pulse to owner.
REQ-008 res  output  8  registered result, valid while done0 or done1 is high.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 alu_a, alu_b  output  8 each  registered operands to the shared ALU units.
REQ-011 en_and, en_or, en_xor, en_add  output  1 each  enables of the enable-gated ALU units.
REQ-012 alu_s  input  8  combinational result of the enabled ALU unit (OR of unit outputs; disabled units drive 0).

Function
REQ-013 FSM states SHALL be IDLE, GRANT, EXEC, RESP; each non-IDLE state lasts exactly one cycle.
REQ-014 IDLE: req0/req1 sampled; no request -> stay IDLE; any request -> GRANT next edge.
REQ-015 On IDLE->GRANT edge: winner latched, its op latched, its a/b loaded into alu_a/alu_b.
REQ-016 Arbitration SHALL be round-robin: single request wins outright; both requesting -> requester other than last granted wins.
REQ-017 Last-granted pointer SHALL update on IDLE->GRANT edge; reset value = requester 1 (so requester 0 wins first tie).
REQ-018 gnt of the winner SHALL be high in GRANT, EXEC and RESP; both gnt never high together.
REQ-019 GRANT -> EXEC unconditionally; en_* all low in GRANT (operand setup cycle).
REQ-020 EXEC: exactly one en_* high, selected by latched op; all others low.
REQ-021 On EXEC->RESP edge res SHALL capture alu_s; ADD result is 8-bit, carry discarded (wrap modulo 256).
REQ-022 RESP: done of the owner high for exactly that cycle; -> IDLE next edge unconditionally.
REQ-023 Latency: request sampled at edge k -> gnt from edge k, en_* during cycle after edge k+1, done after edge k+2, IDLE after edge k+3; one transaction per 4 cycles.
REQ-024 req/op/a/b SHALL be ignored outside IDLE; dropping req after capture does not abort the transaction.
REQ-025 Requester SHALL drop req in its done cycle; req still high in IDLE counts as a new request (round-robin favours the other requester).
REQ-026 res SHALL hold its value until next EXEC->RESP capture; alu_a/alu_b hold until next grant.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE and all outputs 0 (gnt*, done*, res, busy, alu_a, alu_b, en_*), pointer = requester 1.
REQ-028 Reset mid-transaction SHALL discard it with no done pulse; first arbitration after release behaves as after power-up.

Verification
REQ-029 Single AND: req0=1, op0=00, a0=0x35, b0=0x94 -> gnt0 3 cycles, en_and 1 cycle, done0 pulse with res=0x14, gnt1/done1 stay 0.
REQ-030 Simultaneous after reset: req0 (op XOR, 0xAA,0x55), req1 (op OR, 0xE1,0xE1) held -> requester 0 served first res=0xFF, then requester 1 res=0xE1, back-to-back (done1 4 cycles after done0).
REQ-031 ADD wrap: req1, op1=11, a1=0xFF, b1=0x02 -> done1 with res=0x01, only en_add pulsed.
REQ-032 Fairness: both requests held continuously for 4 transactions -> grants alternate 0,1,0,1.
REQ-033 Reset in EXEC: assert rst_n=0 during en_* pulse -> all outputs 0 at once, no done; after release req1 alone -> normal transaction with correct res.
REQ-034 Operand isolation: change a0/b0/op0 during GRANT/EXEC -> res reflects values captured at grant.
